// File: rtl/tlb_op_seq.sv
// Sequencer for committed TLB maintenance ops (tlbrd/tlbwr/tlbfill/invtlb).
// Drives the shared TLB read/write ports and pulses done/refetch on completion.
module tlb_op_seq #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  logic            clk,
  input  logic            resetn,

  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_code,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [18:0]     inv_vppn,
  input  logic [IDXW-1:0] csr_index,

  output logic [IDXW-1:0] r_index,
  input  logic            r_e,
  input  logic            r_g,
  input  logic [9:0]      r_asid,
  input  logic [18:0]     r_vppn,
  input  logic [5:0]      r_ps,

  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic            tlb_w_clr,
  output logic            tlbrd_we,

  output logic [IDXW-1:0] rand_index,
  output logic            busy,
  output logic            done,
  output logic            refetch
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_INV,
    S_FIN
  } state_e;

  localparam logic [2:0]      OP_TLBRD   = 3'd1;
  localparam logic [2:0]      OP_TLBWR   = 3'd2;
  localparam logic [2:0]      OP_TLBFILL = 3'd3;
  localparam logic [2:0]      OP_INVTLB  = 3'd4;
  localparam logic [4:0]      INV_OP_MAX = 5'd6;
  localparam logic [5:0]      PS_HUGE    = 6'd21;
  localparam logic [7:0]      LFSR_SEED  = 8'hA5;
  localparam logic [IDXW-1:0] SCAN_LAST  = IDXW'(TLBNUM - 1);

  state_e          state_q, state_d;
  logic [2:0]      op_code_q;
  logic [4:0]      inv_op_q;
  logic [9:0]      inv_asid_q;
  logic [18:0]     inv_vppn_q;
  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] scan_q, scan_d;
  logic [7:0]      lfsr_q, lfsr_d;

  logic            accept;
  logic            asid_eq;
  logic            vppn_eq;
  logic            inv_hit;

  assign accept     = op_valid && (state_q == S_IDLE);
  assign op_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign refetch    = done;
  assign rand_index = lfsr_q[IDXW-1:0];
  assign lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Huge (2 MB) pages ignore the low VPPN bits that fall inside the page.
  assign asid_eq = (r_asid == inv_asid_q);
  assign vppn_eq = (r_ps == PS_HUGE) ? (r_vppn[18:9] == inv_vppn_q[18:9])
                                     : (r_vppn == inv_vppn_q);

  always_comb begin
    inv_hit = 1'b0;
    case (inv_op_q)
      5'd0, 5'd1: inv_hit = 1'b1;
      5'd2:       inv_hit = r_e && r_g;
      5'd3:       inv_hit = r_e && !r_g;
      5'd4:       inv_hit = r_e && !r_g && asid_eq;
      5'd5:       inv_hit = r_e && !r_g && asid_eq && vppn_eq;
      5'd6:       inv_hit = r_e && (r_g || asid_eq) && vppn_eq;
      default:    inv_hit = 1'b0;
    endcase
  end

  // NOTE: every output and next-state variable gets a default before the case,
  // so no path through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    scan_d      = scan_q;
    r_index     = '0;
    tlb_we      = 1'b0;
    tlb_w_index = '0;
    tlb_w_clr   = 1'b0;
    tlbrd_we    = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_code)
            OP_TLBRD: state_d = S_READ;
            OP_INVTLB: begin
              scan_d  = '0;
              state_d = (inv_op <= INV_OP_MAX) ? S_INV : S_FIN;
            end
            default: state_d = S_WRITE;
          endcase
        end
      end

      S_WRITE: begin
        // Unknown op codes walk the same path but never touch the TLB.
        tlb_we      = (op_code_q == OP_TLBWR) || (op_code_q == OP_TLBFILL);
        tlb_w_index = idx_q;
        state_d     = S_FIN;
      end

      S_READ: begin
        r_index  = idx_q;
        tlbrd_we = 1'b1;
        state_d  = S_FIN;
      end

      S_INV: begin
        r_index = scan_q;
        if (inv_hit) begin
          tlb_we      = 1'b1;
          tlb_w_clr   = 1'b1;
          tlb_w_index = scan_q;
        end
        scan_d = scan_q + IDXW'(1);
        if (scan_q == SCAN_LAST) state_d = S_FIN;
      end

      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      op_code_q  <= '0;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_vppn_q <= '0;
      idx_q      <= '0;
      scan_q     <= '0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      lfsr_q  <= lfsr_d;
      if (accept) begin
        op_code_q  <= op_code;
        inv_op_q   <= inv_op;
        inv_asid_q <= inv_asid;
        inv_vppn_q <= inv_vppn;
        idx_q      <= (op_code == OP_TLBFILL) ? rand_index : csr_index;
      end
    end
  end

endmodule

// File: tb/tb_tlb_op_seq.sv
// Directed self-checking bench for tlb_op_seq: a small TLB array model feeds the
// read port and each step compares the DUT outputs against hand-derived values.
module tb_tlb_op_seq;

  logic        clk;
  logic        resetn;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_code;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_vppn;
  logic [3:0]  csr_index;
  logic [3:0]  r_index;
  logic        r_e;
  logic        r_g;
  logic [9:0]  r_asid;
  logic [18:0] r_vppn;
  logic [5:0]  r_ps;
  logic        tlb_we;
  logic [3:0]  tlb_w_index;
  logic        tlb_w_clr;
  logic        tlbrd_we;
  logic [3:0]  rand_index;
  logic        busy;
  logic        done;
  logic        refetch;

  logic        m_e    [16];
  logic        m_g    [16];
  logic [9:0]  m_asid [16];
  logic [18:0] m_vppn [16];
  logic [5:0]  m_ps   [16];

  int compared   = 0;
  int mismatched = 0;
  int we_cnt;
  int done_cnt;
  logic [15:0] hit_mask;
  logic        clr_seen;

  assign r_e    = m_e[r_index];
  assign r_g    = m_g[r_index];
  assign r_asid = m_asid[r_index];
  assign r_vppn = m_vppn[r_index];
  assign r_ps   = m_ps[r_index];

  tlb_op_seq #(.TLBNUM(16), .IDXW(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_code     (op_code),
    .inv_op      (inv_op),
    .inv_asid    (inv_asid),
    .inv_vppn    (inv_vppn),
    .csr_index   (csr_index),
    .r_index     (r_index),
    .r_e         (r_e),
    .r_g         (r_g),
    .r_asid      (r_asid),
    .r_vppn      (r_vppn),
    .r_ps        (r_ps),
    .tlb_we      (tlb_we),
    .tlb_w_index (tlb_w_index),
    .tlb_w_clr   (tlb_w_clr),
    .tlbrd_we    (tlbrd_we),
    .rand_index  (rand_index),
    .busy        (busy),
    .done        (done),
    .refetch     (refetch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of sequence, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge so registered state has settled.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_model();
    for (int i = 0; i < 16; i++) begin
      m_e[i]    = 1'b0;
      m_g[i]    = 1'b0;
      m_asid[i] = '0;
      m_vppn[i] = '0;
      m_ps[i]   = 6'd12;
    end
  endtask

  // Walk the 16 INV cycles, recording every clear the DUT issues.
  task automatic scan_inv();
    we_cnt   = 0;
    done_cnt = 0;
    hit_mask = '0;
    clr_seen = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      op_valid = 1'b0;
      check($sformatf("scan_r_index_%0d", i), 32'(r_index), 32'(i));
      if (tlb_we) begin
        we_cnt++;
        hit_mask[tlb_w_index] = 1'b1;
        if (!tlb_w_clr) clr_seen = 1'b0;
      end
      if (done) done_cnt++;
    end
  endtask

  initial begin
    resetn    = 1'b0;
    op_valid  = 1'b0;
    op_code   = '0;
    inv_op    = '0;
    inv_asid  = '0;
    inv_vppn  = '0;
    csr_index = '0;
    clr_model();

    #12;
    check("rst_op_ready", 32'(op_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_tlb_we", 32'(tlb_we), 0);
    check("rst_r_index", 32'(r_index), 0);
    check("rst_w_index", 32'(tlb_w_index), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rand", 32'(rand_index), 32'h5);

    // tlbfill in the first active cycle: index taken from LFSR 8'hA5.
    resetn    = 1'b1;
    op_valid  = 1'b1;
    op_code   = 3'd3;
    csr_index = 4'h2;
    cyc();
    op_valid = 1'b0;
    check("fill_we", 32'(tlb_we), 1);
    check("fill_w_index", 32'(tlb_w_index), 32'h5);
    check("fill_clr", 32'(tlb_w_clr), 0);
    check("fill_busy", 32'(busy), 1);
    check("fill_op_ready", 32'(op_ready), 0);
    check("lfsr_step1", 32'(rand_index), 32'hA);
    cyc();
    check("fill_we_off", 32'(tlb_we), 0);
    check("fill_done", 32'(done), 1);
    check("fill_refetch", 32'(refetch), 1);
    check("fill_ready_fin", 32'(op_ready), 0);
    cyc();
    check("fill_idle_ready", 32'(op_ready), 1);
    check("fill_idle_done", 32'(done), 0);

    // tlbrd from csr_index 9.
    op_valid  = 1'b1;
    op_code   = 3'd1;
    csr_index = 4'd9;
    cyc();
    op_valid = 1'b0;
    check("rd_r_index", 32'(r_index), 9);
    check("rd_tlbrd_we", 32'(tlbrd_we), 1);
    check("rd_tlb_we", 32'(tlb_we), 0);
    check("rd_op_ready_n1", 32'(op_ready), 0);
    cyc();
    check("rd_done", 32'(done), 1);
    check("rd_refetch", 32'(refetch), 1);
    check("rd_tlbrd_we_off", 32'(tlbrd_we), 0);
    check("rd_r_index_fin", 32'(r_index), 0);
    check("rd_op_ready_n2", 32'(op_ready), 0);
    cyc();
    check("rd_op_ready_n3", 32'(op_ready), 1);

    // tlbwr to csr_index 14.
    op_valid  = 1'b1;
    op_code   = 3'd2;
    csr_index = 4'hE;
    cyc();
    op_valid = 1'b0;
    check("wr_we", 32'(tlb_we), 1);
    check("wr_w_index", 32'(tlb_w_index), 32'hE);
    check("wr_clr", 32'(tlb_w_clr), 0);
    cyc();
    check("wr_done", 32'(done), 1);
    cyc();

    // Unknown op code: walks WRITE without a write strobe.
    op_valid = 1'b1;
    op_code  = 3'd6;
    cyc();
    op_valid = 1'b0;
    check("noop_we", 32'(tlb_we), 0);
    check("noop_busy", 32'(busy), 1);
    cyc();
    check("noop_done", 32'(done), 1);
    cyc();

    // invtlb with op 7: straight to FIN.
    op_valid = 1'b1;
    op_code  = 3'd4;
    inv_op   = 5'd7;
    cyc();
    op_valid = 1'b0;
    check("badinv_done", 32'(done), 1);
    check("badinv_we", 32'(tlb_we), 0);
    check("badinv_r_index", 32'(r_index), 0);
    cyc();
    check("badinv_ready", 32'(op_ready), 1);

    // invtlb op 5: only entry 3 (non-global, ASID and VPPN match) is cleared.
    clr_model();
    m_e[3] = 1'b1; m_g[3] = 1'b0; m_asid[3] = 10'h12; m_vppn[3] = 19'h1234;
    m_e[7] = 1'b1; m_g[7] = 1'b1; m_asid[7] = 10'h12; m_vppn[7] = 19'h1234;
    m_e[10] = 1'b1; m_g[10] = 1'b0; m_asid[10] = 10'h12; m_vppn[10] = 19'h1235;
    op_valid = 1'b1;
    op_code  = 3'd4;
    inv_op   = 5'd5;
    inv_asid = 10'h12;
    inv_vppn = 19'h1234;
    scan_inv();
    check("inv5_we_cnt", 32'(we_cnt), 1);
    check("inv5_hits", 32'(hit_mask), 32'h0008);
    check("inv5_clr", 32'(clr_seen), 1);
    check("inv5_no_early_done", 32'(done_cnt), 0);
    cyc();
    check("inv5_done_n17", 32'(done), 1);
    cyc();

    // invtlb op 6: huge-page global entry 12 differs only in VPPN[8:0] and is
    // cleared; entry 9 matches by ASID; entry 2 (4K page) and invalid 5 are kept.
    clr_model();
    m_e[12] = 1'b1; m_g[12] = 1'b1; m_asid[12] = 10'h3FF; m_vppn[12] = 19'h12CB; m_ps[12] = 6'd21;
    m_e[2]  = 1'b1; m_g[2]  = 1'b1; m_asid[2]  = 10'h000; m_vppn[2]  = 19'h12CB;
    m_e[5]  = 1'b0; m_g[5]  = 1'b1; m_vppn[5]  = 19'h1234;
    m_e[9]  = 1'b1; m_g[9]  = 1'b0; m_asid[9]  = 10'h12;  m_vppn[9]  = 19'h1234;
    op_valid = 1'b1;
    op_code  = 3'd4;
    inv_op   = 5'd6;
    scan_inv();
    check("inv6_we_cnt", 32'(we_cnt), 2);
    check("inv6_hits", 32'(hit_mask), 32'h1200);
    check("inv6_clr", 32'(clr_seen), 1);
    cyc();
    check("inv6_done", 32'(done), 1);
    cyc();

    // invtlb op 0 with op_valid held through the scan: clears 0..15 in order.
    for (int i = 0; i < 16; i++) m_e[i] = 1'b1;
    op_valid = 1'b1;
    op_code  = 3'd4;
    inv_op   = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      check($sformatf("inv0_we_%0d", i), 32'(tlb_we), 1);
      check($sformatf("inv0_w_index_%0d", i), 32'(tlb_w_index), 32'(i));
      check($sformatf("inv0_ready_%0d", i), 32'(op_ready), 0);
    end
    cyc();
    check("inv0_done", 32'(done), 1);
    check("inv0_ready_fin", 32'(op_ready), 0);
    cyc();
    check("inv0_idle_ready", 32'(op_ready), 1);
    check("inv0_idle_busy", 32'(busy), 0);

    // The held op is accepted now; abort its scan with reset at index 6.
    cyc();
    op_valid = 1'b0;
    check("abort_scan0", 32'(r_index), 0);
    check("abort_busy", 32'(busy), 1);
    repeat (6) cyc();
    check("abort_scan6", 32'(r_index), 6);
    check("abort_we_before", 32'(tlb_we), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("abort_we_async", 32'(tlb_we), 0);
    check("abort_busy_async", 32'(busy), 0);
    check("abort_ready_async", 32'(op_ready), 1);
    done_cnt = 0;
    repeat (3) begin
      cyc();
      if (done) done_cnt++;
    end
    #2;
    resetn = 1'b1;
    #1;
    check("abort_lfsr_seed", 32'(rand_index), 32'h5);
    check("abort_ready_rel", 32'(op_ready), 1);
    we_cnt = 0;
    repeat (20) begin
      cyc();
      if (done) done_cnt++;
      if (tlb_we) we_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 0);
    check("abort_no_write", 32'(we_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tlb_op_seq.md
# tlb_op_seq

Sequencer for the TLB maintenance instructions (tlbrd, tlbwr, tlbfill, invtlb) retired from the WB stage. It accepts one committed TLB op at a time and drives the shared TLB read and write ports over one or more cycles. It supplies the tlbfill replacement index from an internal LFSR. On completion it pulses `done`/`refetch`, which the top level uses to flush and refetch from the instruction after the op.

## Interface
- `TLBNUM`, 16: number of TLB entries.
- `IDXW`, 4: index width, equal to log2(`TLBNUM`).

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `resetn` in 1: reset. One clock; reset is asynchronous and active-low.
- `op_valid` in 1: WB presents a committed TLB op.
- `op_ready` out 1: block accepts an op. Equals 1 only in IDLE.
- `op_code` in 3: 1=tlbrd, 2=tlbwr, 3=tlbfill, 4=invtlb. Any other code is a no-op that completes like tlbwr but without a write.
- `inv_op` in 5: invtlb op field.
- `inv_asid` in 10: invtlb ASID operand (rj).
- `inv_vppn` in 19: invtlb VA[31:13] (rk).
- `csr_index` in IDXW: TLBIDX.Index.
- `r_index` out IDXW: TLB read-port index.
- `r_e` in 1, `r_g` in 1, `r_asid` in 10, `r_vppn` in 19, `r_ps` in 6: TLB read-port data for `r_index`, same cycle.
- `tlb_we` out 1: TLB write strobe.
- `tlb_w_index` out IDXW: TLB write index.
- `tlb_w_clr` out 1: 1 means write E=0 only; 0 means write the full entry from the CSRs.
- `tlbrd_we` out 1: CSR capture of tlbrd data.
- `rand_index` out IDXW: current LFSR index.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `refetch` out 1: one-cycle refetch request, identical to `done`.

## Operation
- States: IDLE, WRITE, READ, INV, FIN.
- Accept: `op_valid & op_ready` in IDLE. The block latches `op_code`, `inv_op`, `inv_asid`, `inv_vppn`, and an index: `csr_index` for tlbrd/tlbwr, `rand_index` for tlbfill.
- Next state after accept:
  - tlbwr, tlbfill, other codes: WRITE.
  - tlbrd: READ.
  - invtlb with `inv_op`≤6: INV, with scan counter = 0.
  - invtlb with `inv_op`>6: FIN directly, no TLB access.
- WRITE (1 cycle): `tlb_we`=1, `tlb_w_index`=latched index, `tlb_w_clr`=0. For other codes `tlb_we`=0. Next state FIN.
- READ (1 cycle): `r_index`=latched index, `tlbrd_we`=1. Next state FIN.
- INV (TLBNUM cycles): `r_index`=scan counter. If the entry matches, `tlb_we`=1, `tlb_w_clr`=1 and `tlb_w_index`=scan counter in the same cycle. The counter increments each cycle. When counter = TLBNUM-1 the next state is FIN.
- Match condition (entry must also have `r_e`=1, except for ops 0/1):
  - ops 0/1: every entry.
  - op 2: `r_g`=1.
  - op 3: `r_g`=0.
  - op 4: `r_g`=0 and ASID equal.
  - op 5: `r_g`=0, ASID equal and VPPN equal.
  - op 6: (`r_g`=1 or ASID equal) and VPPN equal.
- VPPN compare: if `r_ps`=21, compare bits [18:9] only; otherwise compare all 19 bits.
- FIN (1 cycle): `done`=`refetch`=1. Next state IDLE.
- LFSR: 8-bit Fibonacci, reset value 8'hA5, advances every cycle including while busy. Next value = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. `rand_index` = lfsr[IDXW-1:0].
- Outside the states above, `tlb_we`, `tlb_w_clr`, `tlbrd_we`, `done` and `refetch` are 0. `r_index` is 0 when not in READ or INV.

## Timing
- Reset values: state IDLE, `op_ready`=1, `busy`=0, all strobes 0, `r_index`=0, `tlb_w_index`=0, scan counter 0, LFSR 8'hA5.
- Latency from accept in cycle N:
  - tlbwr/tlbfill/tlbrd: action in N+1, `done` in N+2, `op_ready` back to 1 in N+3.
  - invtlb: writes in N+1..N+16, `done` in N+17.
  - invtlb with invalid op: `done` in N+1.
- `op_valid` while busy is ignored, and WB must hold the op. Back-to-back accepts are impossible; the minimum spacing is 3 cycles.
- Read-port data is combinational from `r_index`. A clear decision uses the data read in the same cycle.
- Asserting `resetn` low mid-scan aborts immediately: no further writes, no `done`.

## Test plan
- Reset, then tlbfill accepted in the first active cycle: `tlb_w_index`=5 (LFSR 8'hA5), `tlb_w_clr`=0, `tlb_we` high for exactly 1 cycle, `done` 2 cycles after accept.
- tlbrd with `csr_index`=9: `r_index`=9 and `tlbrd_we`=1 in N+1; `done`/`refetch` in N+2; `op_ready`=0 during N+1..N+2.
- invtlb op 5, ASID 0x12, VPPN 0x1234. Model entry 3 = {e1,g0,asid 0x12,vppn 0x1234,ps12}, entry 7 identical but g=1. Required: exactly one `tlb_we` pulse, with `tlb_w_index`=3 and `tlb_w_clr`=1; `done` at N+17.
- invtlb op 6 against an entry with ps=21 whose VPPN differs only in bits [8:0], g=1: that entry is cleared.
- invtlb op 0 with all entries valid: 16 consecutive writes at indices 0..15. `op_valid` held during the scan is not accepted until after `done`.
- Pull `resetn` low during INV at scan index 6: `tlb_we` drops asynchronously, `done` never fires, and after release `op_ready`=1 and LFSR=8'hA5.
